ps2_rx_controller: RTL
======================

Name: ps2_rx_controller

Overview:
- Sequences reception of PS/2 keyboard frames from the raw ps2_clk/ps2_data lines.
- Validates frame framing (start/parity/stop) and recovers from stalled frames.
- Folds the E0 (extended) and F0 (break) prefix bytes into flags on a single decoded key event.
- Sits between the PS/2 pins and the 7-segment display/key-decode logic; one event per make/break code.

Parameters:
- TIMEOUT_CYCLES, 100000: idle clk cycles inside a frame before abort (1 ms at 100 MHz).
- SYNC_STAGES, 2: flip-flop stages on ps2_clk and ps2_data before use (minimum 2).

Ports:
- clk, input, 1: system clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- ps2_clk, input, 1: raw PS/2 clock from the keyboard, asynchronous.
- ps2_data, input, 1: raw PS/2 data from the keyboard, asynchronous.
- key_code, output, 8: last decoded scan code, excluding prefixes.
- key_extended, output, 1: E0 prefix preceded key_code.
- key_release, output, 1: F0 prefix preceded key_code (break event).
- key_valid, output, 1: one-cycle pulse; key_code and flags are new.
- frame_error, output, 1: one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, bit counter 0, prefix flags 0, timeout counter 0.
- Synchronizers are also cleared by reset.
- Edge detect: fall is asserted for exactly one cycle when the synchronized ps2_clk goes 1->0.
- Sampling: ps2_data (synchronized) is sampled only in a cycle where fall=1.
- IDLE:
  - On fall with data=0 (start bit): go to DATA and clear the bit counter.
  - On fall with data=1: stay in IDLE; no error.
- DATA:
  - On each fall, shift data into the byte LSB-first (first received bit becomes bit 0).
  - After the 8th bit, go to PARITY.
- PARITY:
  - On fall, capture the parity bit and go to STOP.
- STOP:
  - On fall with data=1 and good parity: go to IDLE and run byte decode.
  - Otherwise: go to IDLE, pulse frame_error, and clear both prefix flags.
- Byte decode, in the cycle after the stop-bit fall:
  - 0xE0: set ext_flag. No output.
  - 0xF0: set rel_flag. No output.
  - Any other byte: key_code<=byte, key_extended<=ext_flag, key_release<=rel_flag, key_valid=1 for one cycle, then clear both flags.
- Latency: key_valid rises exactly 1 clk after the cycle in which the stop-bit fall is detected.
- Output hold: key_code, key_extended and key_release hold their values until the next key_valid.
- Timeout:
  - The counter runs in DATA, PARITY and STOP, and resets on every fall.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, clear the prefix flags and the partial byte.
  - The counter is held at 0 in IDLE.
- Simultaneous events: a fall in the same cycle the timeout expires takes priority as a valid edge; the timeout is not taken.
- Repeated prefixes: E0 E0 or F0 F0 sequences keep the flag set; no error.
- Reset mid-frame: the partial frame is discarded with no key_valid and no frame_error. The next start bit is received normally.
- Pulses: key_valid and frame_error are never asserted in the same cycle.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: odd parity is checked; parity mismatch is handled as in the STOP error path (frame_error, byte dropped, flags cleared).
- Undefined: the parity bit is consumed but ignored; only the start bit, stop bit and timeout generate frame_error.

Test Plan:
- Single frame 0x1C, correct odd parity, stop=1, ps2_clk period 60 us -> one key_valid pulse with key_code=0x1C, ext=0, rel=0. No frame_error.
- Frames F0 then 1C -> no valid after F0; one valid with key_code=0x1C, rel=1, ext=0. A following 1C gives rel=0.
- Frames E0, F0, 75 -> a single valid with key_code=0x75, ext=1, rel=1. Flags are 0 afterwards.
- Frame 0x1C with flipped parity (PS2_PARITY_CHECK_EN defined) -> frame_error pulse, no key_valid. A preceding F0 flag is cleared, so the next 1C gives rel=0.
- Stall: start plus 4 data bits, then ps2_clk held high for more than TIMEOUT_CYCLES -> frame_error exactly TIMEOUT_CYCLES after the last fall. A following full 0x29 frame decodes to key_code=0x29.
- rst asserted for 1 cycle after 5 bits of frame 0x1C -> no key_valid or frame_error for that frame; the next full 0x5A frame gives key_code=0x5A.

Source files
------------

// File: rtl/ps2_rx_controller.sv
// rtl/ps2_rx_controller.sv - PS/2 keyboard frame receiver with E0/F0 prefix folding
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_controller #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_valid,
    output logic       frame_error
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_bit;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic [CW-1:0] tmo_cnt;
    logic          ext_flag;
    logic          rel_flag;
    logic          timeout_hit;
    logic          parity_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];

    // The counter would reach TIMEOUT_CYCLES-1 this edge; a coincident fall wins.
    assign timeout_hit = (state != IDLE) && !fall && (tmo_cnt == CW'(TIMEOUT_CYCLES - 2));

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (fall && state == PARITY) begin
            par_bit <= data_bit;
        end
    end

    assign parity_ok = ^{shift_reg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            tmo_cnt      <= '0;
            ext_flag     <= 1'b0;
            rel_flag     <= 1'b0;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            key_valid    <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            frame_error <= 1'b0;

            if (state == IDLE || fall) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (timeout_hit) begin
                state       <= IDLE;
                frame_error <= 1'b1;
                ext_flag    <= 1'b0;
                rel_flag    <= 1'b0;
                shift_reg   <= 8'h00;
                bit_cnt     <= 3'd0;
                tmo_cnt     <= '0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (data_bit && parity_ok) begin
                            if (shift_reg == 8'hE0) begin
                                ext_flag <= 1'b1;
                            end else if (shift_reg == 8'hF0) begin
                                rel_flag <= 1'b1;
                            end else begin
                                key_code     <= shift_reg;
                                key_extended <= ext_flag;
                                key_release  <= rel_flag;
                                key_valid    <= 1'b1;
                                ext_flag     <= 1'b0;
                                rel_flag     <= 1'b0;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            ext_flag    <= 1'b0;
                            rel_flag    <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule
